// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: widths, opcode values and the
// fetch-control state encoding.
package bip_pkg;

    localparam int PC_WIDTH     = 11;
    localparam int INSTR_WIDTH  = 16;
    localparam int OPCODE_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 5'b00000;
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/bip_pc.sv
// Program counter register: increments on i_inc, clears on reset, wraps
// naturally modulo 2^PC_WIDTH.
module bip_pc
    import bip_pkg::*;
#(
    parameter int W = PC_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_pc
);

    logic [W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/bip_fetch_control.sv
// BIP fetch/execute sequencer: FETCH -> WAIT -> EXEC per instruction, holding
// the instruction register and steering the PC from the decoder's WrPC.
module bip_fetch_control
    import bip_pkg::*;
#(
    parameter int PC_WIDTH    = bip_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = bip_pkg::INSTR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [INSTR_WIDTH-1:0]  instr_rdata,
    input  logic                    WrPC,
    output logic [PC_WIDTH-1:0]     prog_addr,
    output logic                    prog_rd_en,
    output logic [OPCODE_WIDTH-1:0] Opcode,
    output logic [PC_WIDTH-1:0]     Operand,
    output logic                    exec_valid,
    output logic                    halted,
    output logic [PC_WIDTH-1:0]     pc
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [INSTR_WIDTH-1:0]  r_ir;
    logic                    w_pc_inc;
    logic                    w_rd_en;
    logic                    w_exec;
    logic                    w_halt;
    logic [PC_WIDTH-1:0]     w_pc;

    bip_pc #(
        .W (PC_WIDTH)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_pc_inc),
        .o_pc  (w_pc)
    );

    // Strobes decode straight from the state register so reset clears them
    // without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_WAIT) begin
                r_ir <= instr_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_inc     = 1'b0;
        w_rd_en      = 1'b0;
        w_exec       = 1'b0;
        w_halt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_rd_en      = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_exec = 1'b1;
                if (WrPC) begin
                    w_pc_inc     = 1'b1;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                w_halt = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign prog_addr  = w_pc;
    assign pc         = w_pc;
    assign prog_rd_en = w_rd_en;
    assign exec_valid = w_exec;
    assign halted     = w_halt;
    assign Opcode     = r_ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign Operand    = r_ir[PC_WIDTH-1:0];

endmodule
